// File: rtl/register_file_2r1w.sv
// Integer register file: 2^N x WIDTH, one synchronous write port, two combinational read ports.
// Register 0 has no storage and always reads as zero.
module register_file_2r1w #(
    parameter int               N     = 5,
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INI   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wenable,
    input  logic [N-1:0]     reg_in,
    input  logic [WIDTH-1:0] din,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b
);

    localparam int NREG = 1 << N;

    logic [WIDTH-1:0] regs_q [1:NREG-1];
    logic [WIDTH-1:0] regs_d [1:NREG-1];

    // Address 0 never matches a loop index, so writes to r0 fall through untouched.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREG; i++) begin
            if (wenable && (reg_in == N'(i))) begin
                regs_d[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= INI;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see stored contents only: no bypass from the write port.
    always_comb begin
        data_a = '0;
        data_b = '0;
        for (int i = 1; i < NREG; i++) begin
            if (a == N'(i)) data_a = regs_q[i];
            if (b == N'(i)) data_b = regs_q[i];
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: reference model of the storage, expected read data
// queued when addresses are driven and compared once the read path has settled.
module tb_register_file_2r1w;

    localparam int N     = 5;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             wenable;
    logic [N-1:0]     reg_in;
    logic [WIDTH-1:0] din;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;

    logic [WIDTH-1:0] model [0:(1<<N)-1];
    logic [WIDTH-1:0] exp_q [$];

    int n_checks;
    int n_pass;

    register_file_2r1w #(.N(N), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .wenable (wenable),
        .reg_in  (reg_in),
        .din     (din),
        .a       (a),
        .b       (b),
        .data_a  (data_a),
        .data_b  (data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rd_model(input logic [N-1:0] addr);
        return (addr == '0) ? '0 : model[addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < (1 << N); i++) model[i] = '0;
    endtask

    // Push expectations for the current a/b, let the combinational path settle, then compare.
    task automatic expect_reads(input string tag);
        exp_q.push_back(rd_model(a));
        exp_q.push_back(rd_model(b));
        #1;
        chk({tag, "_a"}, data_a, exp_q.pop_front());
        chk({tag, "_b"}, data_b, exp_q.pop_front());
    endtask

    // One rising edge; model mirrors what a write-capable edge should do, inputs stay put until +1.
    task automatic tick();
        @(posedge clk);
        if (rst && wenable && (reg_in != '0)) model[reg_in] = din;
        #1;
    endtask

    task automatic wr(input logic [N-1:0] addr, input logic [WIDTH-1:0] data);
        wenable = 1'b1;
        reg_in  = addr;
        din     = data;
        tick();
        wenable = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_model();
        rst = 1'b0; wenable = 1'b0; reg_in = '0; din = '0; a = 5'd15; b = 5'd31;
        #2;
        rst = 1'b1;
        expect_reads("reset");

        // write disabled: nothing lands in r15
        wenable = 1'b0; reg_in = 5'd15; din = 32'd2047; a = 5'd15; b = 5'd15;
        tick(); expect_reads("wdis1");
        tick(); expect_reads("wdis2");
        chk("wdis_const", data_a, 32'd0);

        wr(5'd15, 32'd2047);
        expect_reads("wr15");
        chk("wr15_const", data_b, 32'd2047);

        a = 5'd0; b = 5'd0;
        wr(5'd0, 32'd2047);
        expect_reads("r0");
        chk("r0_const", data_a, 32'd0);

        wr(5'd3, 32'hAAAA5555);
        wr(5'd7, 32'h12345678);
        a = 5'd3; b = 5'd7;
        expect_reads("dual");
        chk("dual_const_a", data_a, 32'hAAAA5555);
        chk("dual_const_b", data_b, 32'h12345678);

        // no forwarding: old value visible while the write is pending
        wenable = 1'b1; reg_in = 5'd3; din = 32'hFFFFFFFF; a = 5'd3; b = 5'd3;
        expect_reads("nofwd_before");
        chk("nofwd_before_const", data_a, 32'hAAAA5555);
        tick();
        wenable = 1'b0;
        expect_reads("nofwd_after");
        chk("nofwd_after_const", data_a, 32'hFFFFFFFF);

        for (int i = 0; i < 60; i++) begin
            wenable = 1'($urandom_range(0, 1));
            reg_in  = N'($urandom_range(0, (1 << N) - 1));
            din     = $urandom;
            a       = (i % 7 == 0) ? reg_in : N'($urandom_range(0, (1 << N) - 1));
            b       = N'($urandom_range(0, (1 << N) - 1));
            expect_reads("rnd_pre");
            tick();
            expect_reads("rnd_post");
        end
        wenable = 1'b0;

        // asynchronous reset between edges, write during reset ignored
        wr(5'd15, 32'd2047);
        a = 5'd15; b = 5'd3;
        expect_reads("pre_rst");
        #2;
        rst = 1'b0;
        clear_model();
        expect_reads("async_rst");
        chk("async_rst_const", data_a, 32'd0);
        wenable = 1'b1; reg_in = 5'd15; din = 32'd5;
        tick();
        expect_reads("wr_in_rst");
        wenable = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        expect_reads("post_rst_idle");
        wr(5'd15, 32'd7);
        expect_reads("post_rst_wr");
        chk("post_rst_wr_const", data_a, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no completion expected finish before 50000");
        $fatal(1);
    end

endmodule

// File: doc/register_file_2r1w.md
# register_file_2r1w

General-purpose integer register file for the processor datapath: 2^N registers of WIDTH bits, one synchronous write port and two asynchronous read ports. Register 0 is hardwired to zero. Sits between decode (operand reads) and writeback (result write).

## Interface

Parameters:
- N, default 5: address width; 2^N registers (32 by default).
- WIDTH, default 32: data width of each register.
- INI, default 0: value loaded into registers 1..2^N-1 on reset. Register 0 always reads 0 regardless of INI.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset.
- wenable  input  1  write enable, sampled at rising clk.
- reg_in  input  N  write address.
- din  input  WIDTH  write data.
- a  input  N  read address, port A.
- b  input  N  read address, port B.
- data_a  output  WIDTH  read data, port A.
- data_b  output  WIDTH  read data, port B.

## Operation

- Storage: registers 1..2^N-1 are WIDTH-bit flops. Register 0 has no storage and is constant 0.
- Write: at rising clk with rst high and wenable=1, reg[reg_in] <= din. If reg_in=0, nothing is written.
- wenable=0: no register changes, whatever reg_in/din are.
- Read A: data_a = (a==0) ? 0 : reg[a]. This is purely combinational from a and the stored contents.
- Read B: the same as read A, using b and data_b. Both ports may address the same register, or the write register, in the same cycle.
- No write-to-read forwarding. During the cycle a write is presented, reads of reg_in return the old contents. The new value appears on the read ports right after the rising edge that performs the write.
- Reset: while rst=0, registers 1..2^N-1 are forced to INI (default 0) asynchronously. Writes are ignored while rst=0.
- Outputs during/after reset: data_a/data_b = INI for nonzero addresses and 0 for address 0.
- Reset mid-operation: asserting rst overrides any pending write in the same cycle. Contents are lost.
- Out-of-range addresses cannot occur: all addresses are exactly N bits.

## Timing

- Write latency: 1 clock. Data presented before rising edge k is readable immediately after edge k, within combinational delay.
- Read latency: 0 cycles. This is a combinational path from a/b to data_a/data_b.
- Reset assertion takes effect immediately, with no clock needed. On deassertion, the first write can occur at the next rising edge with rst high.
- If rst deasserts coincident with a rising edge, that edge performs no write.

## Test plan

- Reset: drive rst=0 for 2 ns, then rst=1. Read a=15, b=31 -> data_a=data_b=0 (INI=0).
- Write/read: wenable=1, reg_in=15, din=2047, a=b=15, clock one edge, then wenable=0 -> data_a=data_b=2047 one time unit after the edge.
- Write disabled: after reset, wenable=0, reg_in=15, din=2047, a=b=15, clock edges -> data_a=data_b=0, never 2047.
- r0 hardwired: wenable=1, reg_in=0, din=2047, a=b=0, clock -> data_a=data_b=0.
- Dual-port and no forwarding, in three steps:
  - Write reg 3 = 0xAAAA5555 and reg 7 = 0x12345678 on successive edges.
  - Set a=3, b=7 -> both values appear simultaneously.
  - Present a write of 0xFFFFFFFF to reg 3 with a=3 -> data_a=0xAAAA5555 before the edge and 0xFFFFFFFF after it.
- Asynchronous reset mid-run: with reg 15=2047, pull rst low between clock edges -> data_a (a=15) goes to 0 without a clock edge. A write presented during reset is not performed.
